// File: rtl/hex_display_arbiter_if.sv
// Requester/display bus bundle for the hex display write-port arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req and payload until ack.
//
// Signals:
//   req, req_addr, req_data, req_window : requester side, one slice per requester
//   lock                                : burst-lock request (only with HEX_ARB_LOCK_EN)
//   ack                                 : one-hot completion pulse per requester
//   hex_addr/hex_data/hex_window/hex_we : display controller write port
//   busy                                : arbiter not idle
// master = requesters plus display sink, slave = arbiter.
interface hex_display_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0]  req_window;
`ifdef HEX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]    lock;
`endif
  logic [NUM_REQ-1:0]    ack;
  logic [1:0]            hex_addr;
  logic [31:0]           hex_data;
  logic [1:0]            hex_window;
  logic                  hex_we;
  logic                  busy;

`ifdef HEX_ARB_LOCK_EN
  modport master (output req, req_addr, req_data, req_window, lock,
                  input  ack, hex_addr, hex_data, hex_window, hex_we, busy);
  modport slave  (input  req, req_addr, req_data, req_window, lock,
                  output ack, hex_addr, hex_data, hex_window, hex_we, busy);
`else
  modport master (output req, req_addr, req_data, req_window,
                  input  ack, hex_addr, hex_data, hex_window, hex_we, busy);
  modport slave  (input  req, req_addr, req_data, req_window,
                  output ack, hex_addr, hex_data, hex_window, hex_we, busy);
`endif
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the hex display write port among NUM_REQ requesters.
// Latency: req sampled at edge T -> hex_we in cycle T+1 -> ack in cycle T+2; one write per 3 cycles.
// Backpressure: requesters hold req until ack; losers simply wait, nothing is dropped.
//
// Ports: clk, rst (async, active-high), bus (hex_display_arbiter_if.slave).
// Optional feature macro HEX_ARB_LOCK_EN: adds lock input and LOCK_MAX burst locking.
// All outputs come straight from flops; req has no combinational path to outputs.
module hex_display_arbiter #(
  parameter int NUM_REQ  = 4
`ifdef HEX_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_display_arbiter_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [1:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         window_q, window_d;
  logic               we_q, we_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  logic [IW-1:0]      pick, cand;
  logic               pick_vld;

`ifdef HEX_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
`endif

  // Scan downward from rr_ptr+NUM_REQ to rr_ptr+1 so the last hit, i.e. the
  // first set bit after rr_ptr, wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    addr_d   = addr_q;
    data_d   = data_q;
    window_d = window_q;
    we_d     = 1'b0;
    ack_d    = '0;
`ifdef HEX_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d = pick;
          // Payload is captured here; later changes by the requester are ignored.
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
              addr_d   = bus.req_addr[2*i +: 2];
              data_d   = bus.req_data[32*i +: 32];
              window_d = bus.req_window[2*i +: 2];
            end
          end
          we_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ack_d   = NUM_REQ'(1) << win_q;
        state_d = ACK;
      end
      ACK: begin
        state_d  = IDLE;
        rr_ptr_d = win_q;
`ifdef HEX_ARB_LOCK_EN
        // Parking the pointer just behind the winner lets it win again next time.
        if (bus.lock[win_q] && (lock_cnt_q < CW'(LOCK_MAX - 1))) begin
          rr_ptr_d   = (win_q == '0) ? IW'(NUM_REQ - 1) : win_q - 1'b1;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
          lock_cnt_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      win_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      window_q <= '0;
      we_q     <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
`ifdef HEX_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      window_q <= window_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
`ifdef HEX_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.hex_addr   = addr_q;
  assign bus.hex_data   = data_q;
  assign bus.hex_window = window_q;
  assign bus.hex_we     = we_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with a grant-order scoreboard.
// Latency: checks hex_we one cycle after sampling and ack one cycle after hex_we.
// Backpressure: requesters hold req until ack, then drop it in the following IDLE cycle.
module tb_hex_display_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  hex_display_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef HEX_ARB_LOCK_EN
  hex_display_arbiter #(.NUM_REQ(N), .LOCK_MAX(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  hex_display_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    int          idx;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [1:0]  win;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  pl_addr [N];
  logic [31:0] pl_data [N];
  logic [1:0]  pl_win  [N];

  bit prev_we = 1'b0;
  bit gap_en  = 1'b0;
  int last_ack_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_pl(input int i, input logic [1:0] a, input logic [31:0] d, input logic [1:0] w);
    pl_addr[i] = a;
    pl_data[i] = d;
    pl_win[i]  = w;
    bus.req_addr[2*i +: 2]    = a;
    bus.req_data[32*i +: 32]  = d;
    bus.req_window[2*i +: 2]  = w;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx  = i;
    e.addr = pl_addr[i];
    e.data = pl_data[i];
    e.win  = pl_win[i];
    sb.push_back(e);
  endtask

  // Monitor: compares each write strobe and ack against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.hex_we) begin
        if (sb.size() == 0) check("we_unexpected", 32'd1, 32'd0);
        else begin
          check("we_addr", {30'd0, bus.hex_addr}, {30'd0, sb[0].addr});
          check("we_data", bus.hex_data, sb[0].data);
          check("we_window", {30'd0, bus.hex_window}, {30'd0, sb[0].win});
        end
      end
      if (bus.ack != '0) begin
        check("ack_after_we", {31'd0, prev_we}, 32'd1);
        if (sb.size() == 0) check("ack_unexpected", {28'd0, bus.ack}, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_onehot", {28'd0, bus.ack}, 32'd1 << e.idx);
        end
        if (gap_en) begin
          if (last_ack_cyc >= 0) check("ack_gap", cyc - last_ack_cyc, 32'd3);
          last_ack_cyc = cyc;
        end
      end
      prev_we = bus.hex_we;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Wait for n acks (bounded); without hold each acked requester drops req in the IDLE cycle.
  task automatic run_acks(input int n, input bit hold);
    int got = 0;
    int t = 0;
    logic [N-1:0] drop = '0;
    while (got < n && t < 200) begin
      @(posedge clk); #1;
      bus.req = bus.req & ~drop;
      drop = '0;
      @(negedge clk);
      t++;
      if (bus.ack != '0) begin
        got++;
        if (!hold) drop = bus.ack;
      end
    end
    @(posedge clk); #1;
    bus.req = hold ? '0 : (bus.req & ~drop);
    check("acks_seen", got, n);
  endtask

  initial begin
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_window = '0;
`ifdef HEX_ARB_LOCK_EN
    bus.lock       = '0;
`endif
    for (int i = 0; i < N; i++) set_pl(i, 2'(i), 32'hC0DE_0000 + i, 2'(3 - i));

    // Reset state
    @(negedge clk);
    check("rst_ack", {28'd0, bus.ack}, 32'd0);
    check("rst_we", {31'd0, bus.hex_we}, 32'd0);
    check("rst_addr", {30'd0, bus.hex_addr}, 32'd0);
    check("rst_data", bus.hex_data, 32'd0);
    check("rst_window", {30'd0, bus.hex_window}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Single request: latency and hold-after-ack
    do_reset();
    set_pl(0, 2'd1, 32'h0000_00AB, 2'd0);
    bus.req = 4'b0001;
    push_exp(0);
    @(negedge clk);
    check("t1_we_early", {31'd0, bus.hex_we}, 32'd0);
    @(negedge clk);
    check("t1_we", {31'd0, bus.hex_we}, 32'd1);
    check("t1_addr", {30'd0, bus.hex_addr}, 32'd1);
    check("t1_data", bus.hex_data, 32'hAB);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("t1_ack", {28'd0, bus.ack}, 32'b0001);
    check("t1_we_off", {31'd0, bus.hex_we}, 32'd0);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    check("t1_ack_off", {28'd0, bus.ack}, 32'd0);
    check("t1_idle", {31'd0, bus.busy}, 32'd0);
    check("t1_data_hold", bus.hex_data, 32'hAB);
    check("t1_sb_empty", sb.size(), 32'd0);

    // All requesting: strict rotation, one ack every 3 cycles
    do_reset();
    for (int i = 0; i < N; i++) set_pl(i, 2'(i), 32'h1111_0000 * (i + 1), 2'(i));
    bus.req = 4'b1111;
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_exp(i);
    gap_en = 1'b1;
    last_ack_cyc = -1;
    run_acks(8, 1'b1);
    gap_en = 1'b0;
    check("t2_sb_empty", sb.size(), 32'd0);

    // Late request during ISSUE; winner's payload change after grant ignored
    do_reset();
    bus.req = 4'b0100;
    push_exp(2);
    @(posedge clk); #1;
    check("t3_in_issue", {31'd0, bus.hex_we}, 32'd1);
    bus.req = bus.req | 4'b0010;
    push_exp(1);
    set_pl(2, 2'd0, 32'hBAD0_0002, 2'd0);
    run_acks(2, 1'b0);
    check("t3_sb_empty", sb.size(), 32'd0);

    // Reset during ISSUE: strobe/ack drop at once, requester 0 then beats 3
    do_reset();
    set_pl(3, 2'd3, 32'h3333_3333, 2'd2);
    set_pl(0, 2'd2, 32'h0000_0F0F, 2'd1);
    bus.req = 4'b1000;
    push_exp(3);
    @(posedge clk); #1;
    check("t4_in_issue", {31'd0, bus.hex_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("t4_we_rst", {31'd0, bus.hex_we}, 32'd0);
    check("t4_ack_rst", {28'd0, bus.ack}, 32'd0);
    check("t4_busy_rst", {31'd0, bus.busy}, 32'd0);
    sb.delete();
    bus.req = 4'b1001;
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(0);
    push_exp(3);
    run_acks(2, 1'b0);
    check("t4_sb_empty", sb.size(), 32'd0);

`ifdef HEX_ARB_LOCK_EN
    // Lock on requester 1 with LOCK_MAX=2
    do_reset();
    bus.lock = 4'b0010;
    bus.req  = 4'b0011;
    push_exp(0); push_exp(1); push_exp(1);
    push_exp(0); push_exp(1); push_exp(1);
    run_acks(6, 1'b1);
    bus.lock = '0;
    check("t5_sb_empty", sb.size(), 32'd0);
`endif

    // Payload change after grant, before ack
    do_reset();
    set_pl(0, 2'd3, 32'h1234_5678, 2'd3);
    bus.req = 4'b0001;
    push_exp(0);
    @(posedge clk); #1;
    set_pl(0, 2'd0, 32'hDEAD_BEEF, 2'd0);
    run_acks(1, 1'b0);
    @(negedge clk);
    check("t6_data_hold", bus.hex_data, 32'h1234_5678);
    check("t6_addr_hold", {30'd0, bus.hex_addr}, 32'd3);
    check("t6_idle", {31'd0, bus.busy}, 32'd0);
    check("t6_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
